adder_operand_sequencer: RTL and testbench
==========================================

Name: adder_operand_sequencer

Overview:
Upstream input stage for the 4-bit hardware adder display path. Synchronises and debounces the two raw pushbuttons, then steps through operand entry: capture operand A from the 4-bit switches, capture operand B, show the sum. Computes the 5-bit sum and drives registered hex digits and per-digit blank flags. The downstream hex-to-7-segment decoders consume these digits for the HEX5..HEX2 and Seg displays.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clocks required before a debounced button changes (10 ms at 50 MHz); minimum 2
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES

Ports:
Clock  input  1  single system clock, all logic on rising edge
Reset_n  input  1  synchronous active-low reset, sampled on rising Clock edge
Hex  input  4  raw slide-switch value, operand source
button  input  2  raw pushbuttons, active-low (0 = pressed); [0] = ENTER, [1] = CLEAR
OpA  output  4  captured operand A
OpB  output  4  captured operand B
Sum  output  5  OpA + OpB, zero-extended, bit 4 = carry
DigitA  output  4  hex digit for A display (= OpA)
DigitB  output  4  hex digit for B display (= OpB)
DigitSumLo  output  4  Sum[3:0]
DigitSumHi  output  4  {3'b000, Sum[4]}
Blank  output  4  per-digit blank flags {A, B, SumHi, SumLo}; 1 = display off
State  output  2  current state encoding
SumValid  output  1  one-cycle pulse when Sum is updated

Behaviour:
- One clock domain; every output is registered. No combinational path from inputs to outputs.
- Reset (Reset_n = 0 at an edge): State = ENTER_A, OpA = OpB = 0, Sum = 0, all digits = 0, Blank = 4'b1111, SumValid = 0, debounced buttons = 1 (released), counters = 0, synchronisers = 2'b11. Reset overrides every other event, including mid-debounce and mid-state.
- Synchroniser: 2-flop per button bit.
- Debounce, per bit: a counter increments on each edge where the synchronised value differs from the debounced value. When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synchronised value at that edge and the counter clears. Any edge where the two values match clears the counter.
- Press event: registered one-cycle pulse on the debounced 1->0 transition. Releases produce no event. Holding a button produces exactly one event.
- Latency: raw press held from edge k gives a press pulse high in the cycle after edge k+2+DEBOUNCE_CYCLES. The state/operand update occurs at the following edge.
- State machine, encoding ENTER_A = 2'd0, ENTER_B = 2'd1, SHOW = 2'd2 (2'd3 is illegal and recovers to ENTER_A with the clear actions):
  - ENTER_A + ENTER event: OpA <= Hex, Blank[3] <= 0, next ENTER_B.
  - ENTER_B + ENTER event: OpB <= Hex, Blank[2] <= 0, Sum <= OpA + Hex, Blank[1:0] <= 2'b00, SumValid = 1 for that cycle, next SHOW.
  - SHOW + ENTER event: Blank <= 4'b0111 (A shown, B and sum blanked), OpA <= Hex, next ENTER_B. This chains a new computation.
  - CLEAR event in any state: OpA = OpB = Sum = 0, Blank = 4'b1111, next ENTER_A.
- Simultaneous ENTER and CLEAR events in the same cycle: CLEAR wins; ENTER is discarded.
- Hex is sampled only on the ENTER-event edge; changes at other times have no effect.
- Arithmetic: unsigned 4+4 -> 5 bits; 15 + 15 = 5'h1E (no saturation).
- Digit outputs always equal the corresponding operand/sum fields, even while blanked.
- SumValid never asserts outside the ENTER_B -> SHOW transition.

Test Plan:
(DEBOUNCE_CYCLES = 4 for simulation.)
- Reset: hold Reset_n = 0 for 3 cycles with button = 2'b00 and Hex = 4'hF -> State = 0, Blank = 4'hF, OpA = OpB = Sum = 0, no SumValid.
- Normal sum: Hex = 3, press/release ENTER; Hex = 5, press/release ENTER -> OpA = 3, OpB = 5, Sum = 5'h08, DigitSumHi = 0, Blank = 4'b0000, exactly one SumValid pulse, State = 2.
- Carry: A = 4'hF, B = 4'hE -> Sum = 5'h1D, DigitSumLo = 4'hD, DigitSumHi = 1.
- Bounce: ENTER toggled every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one press event; press pulse at edge k+2+4 from the start of the stable low; State advances once.
- Clear priority: in SHOW, press ENTER and CLEAR together -> State = ENTER_A, Blank = 4'hF, operands 0. Separately, hold ENTER for 100 cycles -> a single event only.
- Chain and mid-op reset: from SHOW with Hex = 7, press ENTER -> OpA = 7, Blank = 4'b0111, State = 1. Then assert Reset_n = 0 mid-debounce of the next press -> full reset values, and no event after release of reset.

Source files
------------

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Input stage for the 4-bit adder display path. Synchronises and debounces
//   the two raw pushbuttons, then sequences operand entry (A, then B, then
//   show the sum). Drives registered operands, the 5-bit sum, hex digits and
//   per-digit blank flags for the downstream 7-segment decoders.
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset_n     in   synchronous active-low reset
//   Hex         in   raw slide-switch operand value
//   button      in   raw pushbuttons, active-low; [0] = ENTER, [1] = CLEAR
//   OpA, OpB    out  captured operands
//   Sum         out  OpA + OpB, bit 4 = carry
//   DigitA/B    out  hex digits for the operand displays
//   DigitSumLo  out  Sum[3:0]
//   DigitSumHi  out  {3'b000, Sum[4]}
//   Blank       out  blank flags {A, B, SumHi, SumLo}, 1 = off
//   State       out  current state (0 = ENTER_A, 1 = ENTER_B, 2 = SHOW)
//   SumValid    out  one-cycle pulse when Sum is updated
module adder_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] Hex,
    input  logic [1:0] button,
    output logic [3:0] OpA,
    output logic [3:0] OpB,
    output logic [4:0] Sum,
    output logic [3:0] DigitA,
    output logic [3:0] DigitB,
    output logic [3:0] DigitSumLo,
    output logic [3:0] DigitSumHi,
    output logic [3:0] Blank,
    output logic [1:0] State,
    output logic       SumValid
);

    localparam logic [1:0] StEnterA  = 2'd0;
    localparam logic [1:0] StEnterB  = 2'd1;
    localparam logic [1:0] StShow    = 2'd2;

    // The debounced value flips on the edge whose increment would reach
    // DEBOUNCE_CYCLES, so compare against one less.
    localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser, debounce and press detection
    // ------------------------------------------------------------------
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_dly_q;
    logic [1:0]       press_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            db_q     <= 2'b11;
            db_dly_q <= 2'b11;
            press_q  <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            // Falling edge of the debounced level only; releases are ignored.
            press_q  <= db_dly_q & ~db_q;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    logic enter_ev, clear_ev;
    assign enter_ev = press_q[0];
    assign clear_ev = press_q[1];

    // ------------------------------------------------------------------
    // Operand sequencer
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic [4:0] sum_q, sum_d;
    logic [3:0] blank_q, blank_d;
    logic       sum_valid_q, sum_valid_d;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        blank_d     = blank_q;
        sum_valid_d = 1'b0;

        if (clear_ev) begin
            // CLEAR has priority over a simultaneous ENTER.
            state_d = StEnterA;
            op_a_d  = 4'h0;
            op_b_d  = 4'h0;
            sum_d   = 5'h00;
            blank_d = 4'b1111;
        end else begin
            case (state_q)
                StEnterA: begin
                    if (enter_ev) begin
                        op_a_d     = Hex;
                        blank_d[3] = 1'b0;
                        state_d    = StEnterB;
                    end
                end
                StEnterB: begin
                    if (enter_ev) begin
                        op_b_d       = Hex;
                        sum_d        = {1'b0, op_a_q} + {1'b0, Hex};
                        blank_d[2:0] = 3'b000;
                        sum_valid_d  = 1'b1;
                        state_d      = StShow;
                    end
                end
                StShow: begin
                    if (enter_ev) begin
                        // Start the next computation with a fresh A.
                        op_a_d  = Hex;
                        blank_d = 4'b0111;
                        state_d = StEnterB;
                    end
                end
                default: begin
                    state_d = StEnterA;
                    op_a_d  = 4'h0;
                    op_b_d  = 4'h0;
                    sum_d   = 5'h00;
                    blank_d = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= StEnterA;
            op_a_q      <= 4'h0;
            op_b_q      <= 4'h0;
            sum_q       <= 5'h00;
            blank_q     <= 4'b1111;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            blank_q     <= blank_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    // All outputs come straight from registers.
    assign OpA        = op_a_q;
    assign OpB        = op_b_q;
    assign Sum        = sum_q;
    assign DigitA     = op_a_q;
    assign DigitB     = op_b_q;
    assign DigitSumLo = sum_q[3:0];
    assign DigitSumHi = {3'b000, sum_q[4]};
    assign Blank      = blank_q;
    assign State      = state_q;
    assign SumValid   = sum_valid_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// tb_adder_operand_sequencer
//   Directed bench for adder_operand_sequencer with DEBOUNCE_CYCLES = 4.
//   Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_adder_operand_sequencer;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] Hex;
    logic [1:0] button;
    logic [3:0] OpA, OpB, DigitA, DigitB, DigitSumLo, DigitSumHi, Blank;
    logic [4:0] Sum;
    logic [1:0] State;
    logic       SumValid;

    int n_cmp;
    int n_bad;
    int sv_count;

    adder_operand_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Hex       (Hex),
        .button    (button),
        .OpA       (OpA),
        .OpB       (OpB),
        .Sum       (Sum),
        .DigitA    (DigitA),
        .DigitB    (DigitB),
        .DigitSumLo(DigitSumLo),
        .DigitSumHi(DigitSumHi),
        .Blank     (Blank),
        .State     (State),
        .SumValid  (SumValid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (SumValid) sv_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Press with the given active-low pattern, hold long enough to register,
    // then release and let the release debounce settle.
    task automatic press(input logic [1:0] btn);
        button = btn;
        repeat (10) @(negedge Clock);
        button = 2'b11;
        repeat (12) @(negedge Clock);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        sv_count = 0;
        Reset_n  = 1'b0;
        Hex      = 4'hF;
        button   = 2'b00;

        // Reset with buttons held and switches at F.
        repeat (3) @(negedge Clock);
        check_eq("rst_state", 32'(State), 32'd0);
        check_eq("rst_blank", 32'(Blank), 32'hF);
        check_eq("rst_opa", 32'(OpA), 32'h0);
        check_eq("rst_opb", 32'(OpB), 32'h0);
        check_eq("rst_sum", 32'(Sum), 32'h0);
        check_eq("rst_sumvalid", 32'(SumValid), 32'd0);
        button = 2'b11;
        @(negedge Clock);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clock);
        check_eq("post_rst_state", 32'(State), 32'd0);

        // Normal sum 3 + 5.
        sv_count = 0;
        Hex = 4'h3;
        press(2'b10);
        check_eq("a_state", 32'(State), 32'd1);
        check_eq("a_opa", 32'(OpA), 32'h3);
        check_eq("a_blank", 32'(Blank), 32'b0111);
        Hex = 4'h5;
        repeat (3) @(negedge Clock);
        check_eq("a_hex_ignored", 32'(OpA), 32'h3);
        press(2'b10);
        check_eq("n_opa", 32'(OpA), 32'h3);
        check_eq("n_opb", 32'(OpB), 32'h5);
        check_eq("n_sum", 32'(Sum), 32'h08);
        check_eq("n_dhi", 32'(DigitSumHi), 32'h0);
        check_eq("n_dlo", 32'(DigitSumLo), 32'h8);
        check_eq("n_blank", 32'(Blank), 32'b0000);
        check_eq("n_state", 32'(State), 32'd2);
        check_eq("n_sv_count", 32'(sv_count), 32'd1);

        // Chain from SHOW into a carry case: F + E.
        Hex = 4'hF;
        press(2'b10);
        check_eq("c_state_b", 32'(State), 32'd1);
        check_eq("c_blank_b", 32'(Blank), 32'b0111);
        Hex = 4'hE;
        press(2'b10);
        check_eq("c_sum", 32'(Sum), 32'h1D);
        check_eq("c_dlo", 32'(DigitSumLo), 32'hD);
        check_eq("c_dhi", 32'(DigitSumHi), 32'h1);
        check_eq("c_da", 32'(DigitA), 32'hF);
        check_eq("c_db", 32'(DigitB), 32'hE);
        check_eq("c_sv_count", 32'(sv_count), 32'd2);

        // ENTER and CLEAR together in SHOW: CLEAR wins.
        press(2'b00);
        check_eq("clr_state", 32'(State), 32'd0);
        check_eq("clr_blank", 32'(Blank), 32'hF);
        check_eq("clr_opa", 32'(OpA), 32'h0);
        check_eq("clr_opb", 32'(OpB), 32'h0);
        check_eq("clr_sum", 32'(Sum), 32'h0);
        check_eq("clr_sv_count", 32'(sv_count), 32'd2);

        // Bounce: 20 cycles toggling every 2, ending released, then stable low.
        Hex = 4'h9;
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0) ? 2'b10 : 2'b11;
            repeat (2) @(negedge Clock);
        end
        check_eq("bnc_no_event", 32'(State), 32'd0);
        button = 2'b10;
        // Press pulse after edge k+6, state update at edge k+7.
        repeat (7) @(negedge Clock);
        check_eq("bnc_before", 32'(State), 32'd0);
        @(negedge Clock);
        check_eq("bnc_after", 32'(State), 32'd1);
        check_eq("bnc_opa", 32'(OpA), 32'h9);
        repeat (2) @(negedge Clock);
        button = 2'b11;
        repeat (12) @(negedge Clock);
        check_eq("bnc_once", 32'(State), 32'd1);

        // Long hold of ENTER in ENTER_B gives exactly one event.
        Hex = 4'h6;
        button = 2'b10;
        repeat (100) @(negedge Clock);
        check_eq("hold_state", 32'(State), 32'd2);
        check_eq("hold_sum", 32'(Sum), 32'h0F);
        check_eq("hold_sv_count", 32'(sv_count), 32'd3);
        button = 2'b11;
        repeat (12) @(negedge Clock);
        check_eq("hold_release", 32'(State), 32'd2);

        // Chain with A = 7, then reset in the middle of the next debounce.
        Hex = 4'h7;
        press(2'b10);
        check_eq("ch_opa", 32'(OpA), 32'h7);
        check_eq("ch_blank", 32'(Blank), 32'b0111);
        check_eq("ch_state", 32'(State), 32'd1);
        button = 2'b10;
        repeat (4) @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        button = 2'b11;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clock);
        check_eq("mr_state", 32'(State), 32'd0);
        check_eq("mr_opa", 32'(OpA), 32'h0);
        check_eq("mr_opb", 32'(OpB), 32'h0);
        check_eq("mr_sum", 32'(Sum), 32'h0);
        check_eq("mr_blank", 32'(Blank), 32'hF);
        check_eq("mr_sv_count", 32'(sv_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
